fifo_rd_packer: RTL
===================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter WBYTES, default 4, meaning the output word width in bytes (legal 2..8).
REQ-002 SHALL have parameter CNTW, default 16, meaning the pkt_count width.
REQ-003 rclk  input  1  sole clock, rising edge.
REQ-004 rrst  input  1  reset, asynchronous, active-low.
REQ-005 rdata  input  8  FIFO read data, valid whenever empty=0.
REQ-006 empty  input  1  FIFO empty flag, registered in the FIFO, reflects pops.
REQ-007 read  output  1  FIFO pop request; a byte is consumed on each rclk edge with read=1 and empty=0.
REQ-008 out_data  output  8*WBYTES  packed word, byte 0 in bits [7:0] (little-endian lanes).
REQ-009 out_keep  output  WBYTES  valid-lane mask, always contiguous from lane 0.
REQ-010 out_last  output  1  word carries the final byte of a packet.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
REQ-013 pkt_count  output  CNTW  completed-packet counter, wraps modulo 2^CNTW.
REQ-014 busy  output  1  1 when state is not S_HDR or out_valid=1.

Function
REQ-015 The input byte stream SHALL be framed as a 1-byte length header L, followed by L payload bytes.
REQ-016 The FSM SHALL have states S_HDR (await header), S_PAY (collect payload), and S_HOLD (completed word is blocked by a full output register).
REQ-017 In S_HDR, a popped byte L=0 SHALL be discarded, the FSM SHALL stay in S_HDR, and no output word or count change SHALL result.
REQ-018 In S_HDR, a popped byte L>0 SHALL load remaining=L, set lane index to 0, and move the FSM to S_PAY.
REQ-019 In S_PAY, each popped byte SHALL be written to accumulator lane idx; then idx increments and remaining decrements.
REQ-020 A word SHALL be complete when idx reaches WBYTES or remaining reaches 0.
REQ-021 A completed word SHALL transfer to the output register in the same edge if the register is empty or is being drained that cycle; otherwise the FSM SHALL enter S_HOLD.
REQ-022 In S_HOLD, read SHALL be 0, and the word SHALL transfer on the first edge the output register frees.
REQ-023 After the transfer of a word with remaining=0, the FSM SHALL go to S_HDR; otherwise it SHALL go to S_PAY with idx=0.
REQ-024 Latency SHALL be 1 cycle: a word SHALL show out_valid=1 on the cycle after the pop of its final byte, when unblocked.
REQ-025 out_keep SHALL be (1<<n)-1, where n is the number of filled lanes, and unfilled lanes SHALL be driven 0.
REQ-026 out_last SHALL be 1 only on the word containing payload byte L.
REQ-027 out_data, out_keep and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 read SHALL equal ~empty & (state!=S_HOLD) & rrst, combinationally; this permits 1 byte/cycle sustained when out_ready=1.
REQ-029 pkt_count SHALL increment on each edge with out_valid & out_ready & out_last, wrapping from 2^CNTW-1 to 0.
REQ-030 A header byte popped in the same cycle the previous packet's last word drains SHALL be accepted with no bubble.

Reset
REQ-031 While rrst=0, the block SHALL hold state=S_HDR, idx=0, remaining=0, accumulator=0, out_valid=0, out_data=0, out_keep=0, out_last=0, pkt_count=0, and read=0.
REQ-032 A reset assertion mid-packet SHALL discard the partial packet and the output register, and the first byte popped after release SHALL be treated as a header.

Structure
REQ-033 Package fifo_rd_pkg SHALL hold the state enum (S_HDR, S_PAY, S_HOLD), the WBYTES default, and the CNTW default.
REQ-034 The output holding register (data/keep/last/valid with ready handshake) SHALL be the single sub-module fifo_rd_outreg.

Verification
REQ-035 Header 8 + bytes 01..08, out_ready=1 -> 0x04030201 keep F last 0, then 0x08070605 keep F last 1; pkt_count=1.
REQ-036 Header 5 + AA BB CC DD EE -> 0xDDCCBBAA keep F last 0, then 0x000000EE keep 1 last 1.
REQ-037 Header 00, then header 01 + 55 -> exactly one word 0x00000055 keep 1 last 1; pkt_count=1.
REQ-038 Header 12 + 12 bytes, out_ready=0 -> read drops to 0 once the second word is complete and out_data stays stable; out_ready=1 -> three words in order, last on the third.
REQ-039 empty toggled every cycle during header 4 + 11 22 33 44 -> no pop while empty=1, result 0x44332211 keep F last 1.
REQ-040 rrst pulsed low after 3 payload bytes of a header-8 packet -> out_valid=0 and pkt_count=0 at once; after release, a next byte 02 acts as a header and 02 + AB CD gives 0x0000CDAB keep 3 last 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side packet packer.
package fifo_rd_pkg;

    // Default output word width in bytes and packet counter width.
    localparam int WBYTES_DEF = 4;
    localparam int CNTW_DEF   = 16;

    // Packer control states: waiting for a length header, collecting payload,
    // or holding a completed word that the output register cannot take yet.
    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word output stream of the packer.
interface fifo_rd_packer_if #(
    parameter int WBYTES = 4
);
    logic [7:0]          rdata;
    logic                empty;
    logic                read;
    logic [8*WBYTES-1:0] out_data;
    logic [WBYTES-1:0]   out_keep;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;

    // The packer drives the pop request and the output word.
    modport master (
        input  rdata,
        input  empty,
        input  out_ready,
        output read,
        output out_data,
        output out_keep,
        output out_last,
        output out_valid
    );

    // The surrounding FIFO and downstream consumer.
    modport slave (
        output rdata,
        output empty,
        output out_ready,
        input  read,
        input  out_data,
        input  out_keep,
        input  out_last,
        input  out_valid
    );
endinterface

// File: rtl/fifo_rd_outreg.sv
// Single-entry output holding register with valid/ready handshake.
module fifo_rd_outreg #(
    parameter int WBYTES = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                load,
    input  logic [8*WBYTES-1:0] load_data,
    input  logic [WBYTES-1:0]   load_keep,
    input  logic                load_last,
    input  logic                out_ready,
    output logic [8*WBYTES-1:0] out_data,
    output logic [WBYTES-1:0]   out_keep,
    output logic                out_last,
    output logic                out_valid,
    output logic                free
);

    // Register can accept a new word if it is empty or being drained now.
    assign free = ~out_valid | out_ready;

    // Word payload only changes on a load, so it stays stable while stalled.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_data <= load_data;
            out_keep <= load_keep;
            out_last <= load_last;
        end
    end

    // Valid sets on load and clears when the consumer takes the word.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops length-prefixed packets from a byte FIFO and packs the payload into
// little-endian words of WBYTES lanes with keep/last framing.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int WBYTES = WBYTES_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_rd_packer_if.master bus,
    output logic [CNTW-1:0]  pkt_count,
    output logic             busy
);

    // Lane index must be able to hold WBYTES itself (a full word).
    localparam int IDXW = $clog2(WBYTES + 1);

    state_t              state_reg, state_next;
    logic [IDXW-1:0]     idx_reg, idx_next;
    logic [7:0]          remaining_reg, remaining_next;
    logic [8*WBYTES-1:0] acc_reg, acc_next;

    logic                pop;
    logic                free;
    logic                load;
    logic [8*WBYTES-1:0] load_data;
    logic [WBYTES-1:0]   load_keep;
    logic                load_last;

    logic [IDXW-1:0]     idx_inc;
    logic [8*WBYTES-1:0] lane_word;
    logic [WBYTES-1:0]   keep_pay;
    logic [WBYTES-1:0]   keep_hold;

    // Pop whenever data is present and no completed word is parked; gated by
    // reset so nothing is consumed while the block is held in reset.
    assign bus.read = ~bus.empty & (state_reg != S_HOLD) & rrst;
    assign pop      = bus.read;
    assign idx_inc  = idx_reg + IDXW'(1);
    assign busy     = (state_reg != S_HDR) | bus.out_valid;

    // Per-lane merge of the incoming byte and the keep masks for a word that
    // completes this cycle (idx+1 lanes) or one parked in S_HOLD (idx lanes).
    generate
        for (genvar gi = 0; gi < WBYTES; gi++) begin : g_lane
            assign lane_word[8*gi +: 8] = (IDXW'(gi) == idx_reg) ? bus.rdata
                                                                 : acc_reg[8*gi +: 8];
            assign keep_pay[gi]  = (IDXW'(gi) < idx_inc);
            assign keep_hold[gi] = (IDXW'(gi) < idx_reg);
        end
    endgenerate

    // Next-state and word-assembly decisions.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        remaining_next = remaining_reg;
        acc_next       = acc_reg;
        load           = 1'b0;
        load_data      = acc_reg;
        load_keep      = keep_hold;
        load_last      = (remaining_reg == 8'd0);

        case (state_reg)
            S_HDR: begin
                // A zero-length header is simply dropped.
                if (pop && (bus.rdata != 8'd0)) begin
                    remaining_next = bus.rdata;
                    idx_next       = '0;
                    acc_next       = '0;
                    state_next     = S_PAY;
                end
            end
            S_PAY: begin
                if (pop) begin
                    remaining_next = remaining_reg - 8'd1;
                    if ((idx_inc == IDXW'(WBYTES)) || (remaining_reg == 8'd1)) begin
                        if (free) begin
                            load       = 1'b1;
                            load_data  = lane_word;
                            load_keep  = keep_pay;
                            load_last  = (remaining_reg == 8'd1);
                            acc_next   = '0;
                            idx_next   = '0;
                            state_next = (remaining_reg == 8'd1) ? S_HDR : S_PAY;
                        end else begin
                            // Park the finished word until the output frees up.
                            acc_next   = lane_word;
                            idx_next   = idx_inc;
                            state_next = S_HOLD;
                        end
                    end else begin
                        acc_next = lane_word;
                        idx_next = idx_inc;
                    end
                end
            end
            S_HOLD: begin
                if (free) begin
                    load       = 1'b1;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = (remaining_reg == 8'd0) ? S_HDR : S_PAY;
                end
            end
            default: begin
                state_next = S_HDR;
            end
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state_reg     <= S_HDR;
            idx_reg       <= '0;
            remaining_reg <= '0;
            acc_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            remaining_reg <= remaining_next;
            acc_reg       <= acc_next;
        end
    end

    // Completed-packet counter, wraps naturally at 2^CNTW.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            pkt_count <= '0;
        end else if (bus.out_valid & bus.out_ready & bus.out_last) begin
            pkt_count <= pkt_count + CNTW'(1);
        end
    end

    fifo_rd_outreg #(
        .WBYTES (WBYTES)
    ) u_outreg (
        .rclk      (rclk),
        .rrst      (rrst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_keep  (bus.out_keep),
        .out_last  (bus.out_last),
        .out_valid (bus.out_valid),
        .free      (free)
    );

endmodule
